// File: rtl/fp_div_pkg.sv
// Shared encodings and constants for the single-precision divider slice.
// FTOI_SATURATE_EN selects saturating overflow results in ovf_result().
package fp_div_pkg;

  localparam logic [2:0] S_GET_Z   = 3'd0;
  localparam logic [2:0] S_UNPACK  = 3'd1;
  localparam logic [2:0] S_SPECIAL = 3'd2;
  localparam logic [2:0] S_CONVERT = 3'd3;
  localparam logic [2:0] S_PACK    = 3'd4;
  localparam logic [2:0] S_PUT_I   = 3'd5;

  localparam int          FP32_BIAS    = 127;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
  localparam logic [31:0] INT32_MIN    = 32'h8000_0000;
  localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;

  function automatic logic [31:0] ovf_result(input logic neg);
`ifdef FTOI_SATURATE_EN
    return neg ? INT32_MIN : INT32_MAX;
`else
    return neg ? INT32_MIN : INT32_MIN;
`endif
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational class decode of a raw IEEE-754 single-precision word.
// Shared with the divider's special-case handling.
module fp32_classify
  import fp_div_pkg::*;
(
  input  logic [31:0] z_i,
  output logic        is_nan_o,
  output logic        is_inf_o,
  output logic        is_zero_or_denorm_o
);

  logic exp_max;
  logic frac_nz;

  assign exp_max  = (z_i[30:23] == FP32_EXP_MAX);
  assign frac_nz  = |z_i[22:0];

  assign is_nan_o = exp_max && frac_nz;
  assign is_inf_o = exp_max && !frac_nz;
  assign is_zero_or_denorm_o = (z_i[30:23] == 8'h00);

endmodule

// File: rtl/fp32_to_int32_sink.sv
// FP32 -> INT32 converter behind the divider; truncates toward zero with a
// one-bit-per-cycle shifter. FTOI_SATURATE_EN enables saturating overflow.
module fp32_to_int32_sink
  import fp_div_pkg::*;
#(
  parameter int BIAS  = FP32_BIAS,
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      input_z,
  input  logic             input_z_stb,
  output logic             input_z_ack,
  output logic [INT_W-1:0] output_i,
  output logic             output_i_stb,
  input  logic             output_i_ack,
  output logic             output_invalid
);

  if (INT_W != 32) begin : g_bad_width
    $error("fp32_to_int32_sink: INT_W must be 32");
  end

  logic [2:0]        state_q, state_d;
  logic [31:0]       z_q, z_d;
  logic [31:0]       m_q, m_d;
  logic signed [9:0] e_q, e_d;
  logic              s_q, s_d;
  logic [31:0]       out_q, out_d;
  logic              inv_q, inv_d;
  logic              ack_q, ack_d;
  logic              stb_q, stb_d;

  logic              is_nan, is_inf, is_zd;
  logic              sp_hit;
  logic [31:0]       sp_val;
  logic              sp_inv;

  fp32_classify u_cls (
    .z_i                 (z_q),
    .is_nan_o            (is_nan),
    .is_inf_o            (is_inf),
    .is_zero_or_denorm_o (is_zd)
  );

  // First match wins; -2^31 is the only exactly representable e==31 value.
  always_comb begin
    sp_hit = 1'b1;
    sp_val = 32'h0;
    sp_inv = 1'b0;
    if (is_nan) begin
      sp_val = INT32_MIN;
      sp_inv = 1'b1;
    end else if (is_inf) begin
      sp_val = ovf_result(s_q);
      sp_inv = 1'b1;
    end else if (z_q == 32'hCF00_0000) begin
      sp_val = INT32_MIN;
    end else if (e_q > 10'sd30) begin
      sp_val = ovf_result(s_q);
      sp_inv = 1'b1;
    end else if (is_zd || e_q < 10'sd0) begin
      sp_val = 32'h0;
    end else begin
      sp_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_GET_Z;
      z_q     <= 32'h0;
      m_q     <= 32'h0;
      e_q     <= 10'sd0;
      s_q     <= 1'b0;
      out_q   <= 32'h0;
      inv_q   <= 1'b0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      m_q     <= m_d;
      e_q     <= e_d;
      s_q     <= s_d;
      out_q   <= out_d;
      inv_q   <= inv_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GET_Z:   if (ack_q && input_z_stb) state_d = S_UNPACK;
      S_UNPACK:  state_d = S_SPECIAL;
      S_SPECIAL: state_d = sp_hit ? S_PUT_I : S_CONVERT;
      S_CONVERT: if (e_q == 10'sd31) state_d = S_PACK;
      S_PACK:    state_d = S_PUT_I;
      S_PUT_I:   if (stb_q && output_i_ack) state_d = S_GET_Z;
      default:   state_d = S_GET_Z;
    endcase
  end

  always_comb begin
    z_d   = z_q;
    m_d   = m_q;
    e_d   = e_q;
    s_d   = s_q;
    out_d = out_q;
    inv_d = inv_q;
    ack_d = ack_q;
    stb_d = stb_q;
    case (state_q)
      S_GET_Z: begin
        ack_d = 1'b1;
        if (ack_q && input_z_stb) begin
          z_d   = input_z;
          ack_d = 1'b0;
        end
      end
      S_UNPACK: begin
        m_d = {1'b1, z_q[22:0], 8'h00};
        e_d = {2'b00, z_q[30:23]} - 10'(BIAS);
        s_d = z_q[31];
      end
      S_SPECIAL: begin
        if (sp_hit) begin
          out_d = sp_val;
          inv_d = sp_inv;
        end
      end
      S_CONVERT: begin
        if (e_q < 10'sd31) begin
          m_d = m_q >> 1;
          e_d = e_q + 10'sd1;
        end
      end
      S_PACK: begin
        out_d = s_q ? -m_q : m_q;
        inv_d = 1'b0;
      end
      S_PUT_I: begin
        stb_d = !(stb_q && output_i_ack);
      end
      default: ;
    endcase
  end

  assign input_z_ack    = ack_q;
  assign output_i       = out_q;
  assign output_i_stb   = stb_q;
  assign output_invalid = inv_q;

endmodule

// File: tb/tb_fp32_to_int32_sink.sv
// Directed bench for fp32_to_int32_sink: values, latency, specials,
// backpressure and mid-conversion reset.
module tb_fp32_to_int32_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_z;
  logic        input_z_stb;
  logic        input_z_ack;
  logic [31:0] output_i;
  logic        output_i_stb;
  logic        output_i_ack;
  logic        output_invalid;

  int checks   = 0;
  int failures = 0;

`ifdef FTOI_SATURATE_EN
  localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] POS_OVF = 32'h8000_0000;
`endif

  always #5 clk = ~clk;

  fp32_to_int32_sink dut (
    .clk            (clk),
    .rst            (rst),
    .input_z        (input_z),
    .input_z_stb    (input_z_stb),
    .input_z_ack    (input_z_ack),
    .output_i       (output_i),
    .output_i_stb   (output_i_stb),
    .output_i_ack   (output_i_ack),
    .output_invalid (output_invalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Hand one word over and wait for the result strobe.
  task automatic issue(input logic [31:0] z, output int lat);
    int w;
    input_z     = z;
    input_z_stb = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!input_z_ack && w < 20);
    chk("ack_wait", 32'(input_z_ack), 32'd1);
    @(posedge clk);
    #1 input_z_stb = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!output_i_stb && lat < 100);
  endtask

  task automatic take();
    output_i_ack = 1'b1;
    @(posedge clk);
    #1 output_i_ack = 1'b0;
    chk("stb_drop", 32'(output_i_stb), 32'd0);
  endtask

  task automatic conv(input string tag, input logic [31:0] z,
                      input logic [31:0] ei, input logic einv,
                      input int elat);
    int lat;
    issue(z, lat);
    chk({tag, "_stb"}, 32'(output_i_stb), 32'd1);
    chk({tag, "_val"}, output_i, ei);
    chk({tag, "_inv"}, 32'(output_invalid), 32'(einv));
    if (elat > 0) chk({tag, "_lat"}, 32'(lat), 32'(elat));
    take();
  endtask

  initial begin
    int lat;
    logic [31:0] hold;
    rst          = 1'b1;
    input_z      = 32'h0;
    input_z_stb  = 1'b0;
    output_i_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(input_z_ack), 32'd0);
    chk("rst_stb", 32'(output_i_stb), 32'd0);
    chk("rst_out", output_i, 32'h0);
    chk("rst_inv", 32'(output_invalid), 32'd0);
    rst = 1'b0;

    conv("one",   32'h3F80_0000, 32'h0000_0001, 1'b0, 36);
    conv("n123",  32'h42F6_0000, 32'h0000_007B, 1'b0, 30);
    conv("m2p5",  32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 35);
    conv("p075",  32'h3F40_0000, 32'h0000_0000, 1'b0, 3);
    conv("min",   32'hCF00_0000, 32'h8000_0000, 1'b0, 3);
    conv("p2_31", 32'h4F00_0000, POS_OVF,       1'b1, 3);
    conv("maxf",  32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 6);
    conv("nan",   32'h7FC0_0000, 32'h8000_0000, 1'b1, 3);
    conv("ninf",  32'hFF80_0000, 32'h8000_0000, 1'b1, 3);
    conv("pinf",  32'h7F80_0000, POS_OVF,       1'b1, 3);
    conv("denrm", 32'h0000_0001, 32'h0000_0000, 1'b0, 3);
    conv("mzero", 32'h8000_0000, 32'h0000_0000, 1'b0, 3);
    conv("m7",    32'hC0E0_0000, 32'hFFFF_FFF9, 1'b0, 34);

    issue(32'h4040_0000, lat);
    chk("bp_first", output_i, 32'h0000_0003);
    hold = output_i;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_stb", 32'(output_i_stb), 32'd1);
      chk("bp_val", output_i, hold);
      chk("bp_zack", 32'(input_z_ack), 32'd0);
    end
    output_i_ack = 1'b1;
    @(posedge clk);
    #1 output_i_ack = 1'b0;
    chk("rel_stb", 32'(output_i_stb), 32'd0);
    chk("rel_zack0", 32'(input_z_ack), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_zack1", 32'(input_z_ack), 32'd1);

    input_z     = 32'h3F80_0000;
    input_z_stb = 1'b1;
    @(posedge clk);
    #1 input_z_stb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", 32'(output_i_stb), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_stb", 32'(output_i_stb), 32'd0);
    chk("mr_ack", 32'(input_z_ack), 32'd0);
    chk("mr_out", output_i, 32'h0);
    rst = 1'b0;
    conv("three", 32'h4040_0000, 32'h0000_0003, 1'b0, 35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
